// File: rtl/basic_computer_pkg.sv
// Shared types and constants for the basic computer control unit timing logic.
package basic_computer_pkg;

    // Width of the step code handed to the 3-to-8 timing decoder.
    localparam int SC_W = 3;

    // Highest timing step an instruction may reach (T7).
    localparam logic [SC_W-1:0] T_LAST = 3'd7;

    // Sequence-counter control states.
    typedef enum logic [1:0] {
        HALTED    = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2
    } sc_state_t;

endpackage : basic_computer_pkg

// File: rtl/sequence_counter_ctrl_rise_detect.sv
// Single-flop rising-edge detector used to turn the level-sensitive
// single-step request into a one-cycle advance qualifier.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o
);

    logic level_d_r;

    // Remember the previous sample of the level input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_i;
        end
    end

    // A rise is a high sample whose predecessor was low.
    assign rise_o = level_i & ~level_d_r;

endmodule : rise_detect

// File: rtl/sequence_counter_ctrl.sv
// Timing-step generator: owns the S (run) flip-flop and the step sequence
// counter SC that drives the T0..T7 decoder. Supports free run, halt,
// stall and single-step, and latches an error if an instruction runs past
// the last legal step without clearing SC.
module sequence_counter_ctrl
    import basic_computer_pkg::*;
#(
    parameter int CODE_W    = SC_W,
    parameter int LAST_STEP = int'(T_LAST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              hlt_i,
    input  logic              sc_clr_i,
    input  logic              stall_i,
    input  logic              step_mode_i,
    input  logic              step_i,
    output logic [CODE_W-1:0] sc_code_o,
    output logic              run_o,
    output logic              instr_done_o,
    output logic              wrap_err_o
);

    // Wrap point as a code-width constant; may sit below the all-ones code.
    localparam logic [CODE_W-1:0] LAST_C = LAST_STEP[CODE_W-1:0];
    localparam logic [CODE_W-1:0] ZERO_C = {CODE_W{1'b0}};
    localparam logic [CODE_W-1:0] ONE_C  = {{(CODE_W-1){1'b0}}, 1'b1};

    sc_state_t         state_r;
    sc_state_t         state_s;
    logic [CODE_W-1:0] sc_r;
    logic [CODE_W-1:0] sc_s;
    logic              run_r;
    logic              run_s;
    logic              done_r;
    logic              done_s;
    logic              wrap_r;
    logic              wrap_s;
    logic              step_rise_s;
    logic              advance_s;

    rise_detect u_step_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (step_i),
        .rise_o  (step_rise_s)
    );

    // Next-state, next-count and flag logic; priority hlt > clear > stall > advance.
    always_comb begin
        state_s   = state_r;
        sc_s      = sc_r;
        done_s    = 1'b0;
        wrap_s    = wrap_r;
        advance_s = 1'b0;

        case (state_r)
            HALTED: begin
                sc_s = ZERO_C;
                if (start_i) begin
                    wrap_s = 1'b0;
                    if (step_mode_i) begin
                        state_s = STEP_WAIT;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = HALTED;
                end
            end

            RUN, STEP_WAIT: begin
                if (hlt_i) begin
                    sc_s    = ZERO_C;
                    state_s = HALTED;
                end else if (sc_clr_i) begin
                    sc_s   = ZERO_C;
                    done_s = 1'b1;
                end else if (stall_i) begin
                    sc_s = sc_r;
                end else if ((state_r == RUN) || step_rise_s) begin
                    advance_s = 1'b1;
                end else begin
                    sc_s = sc_r;
                end

                // Running off the last step wraps to T0 and is remembered.
                if (advance_s) begin
                    if (sc_r == LAST_C) begin
                        sc_s   = ZERO_C;
                        wrap_s = 1'b1;
                    end else begin
                        sc_s = sc_r + ONE_C;
                    end
                end else begin
                    wrap_s = wrap_s;
                end
            end

            default: begin
                state_s = HALTED;
                sc_s    = ZERO_C;
                done_s  = 1'b0;
                wrap_s  = wrap_r;
            end
        endcase

        run_s = (state_s != HALTED);
    end

    // State, sequence counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= HALTED;
            sc_r    <= ZERO_C;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sc_r    <= sc_s;
            run_r   <= run_s;
            done_r  <= done_s;
            wrap_r  <= wrap_s;
        end
    end

    assign sc_code_o    = sc_r;
    assign run_o        = run_r;
    assign instr_done_o = done_r;
    assign wrap_err_o   = wrap_r;

endmodule : sequence_counter_ctrl

// File: tb/tb_sequence_counter_ctrl.sv
// Self-checking bench for sequence_counter_ctrl: a behavioural model of the
// S flip-flop / SC rules is compared against the DUT every falling edge,
// and directed steps pin hand-computed values.
module tb_sequence_counter_ctrl;

    localparam int LAST = 7;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       hlt_i;
    logic       sc_clr_i;
    logic       stall_i;
    logic       step_mode_i;
    logic       step_i;
    logic [2:0] sc_code_o;
    logic       run_o;
    logic       instr_done_o;
    logic       wrap_err_o;

    int n_compared;
    int n_mismatched;

    // Behavioural model state (plain integers and booleans).
    int m_sc;
    bit m_running;
    bit m_single;
    bit m_done;
    bit m_wrap;
    bit m_prev_step;
    bit m_rise;

    sequence_counter_ctrl #(.CODE_W(3), .LAST_STEP(LAST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .hlt_i        (hlt_i),
        .sc_clr_i     (sc_clr_i),
        .stall_i      (stall_i),
        .step_mode_i  (step_mode_i),
        .step_i       (step_i),
        .sc_code_o    (sc_code_o),
        .run_o        (run_o),
        .instr_done_o (instr_done_o),
        .wrap_err_o   (wrap_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_compared = n_compared + 1;
        if (act != exp) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the outputs must be after each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sc = 0; m_running = 0; m_single = 0;
            m_done = 0; m_wrap = 0; m_prev_step = 0;
        end else begin
            m_rise      = step_i && !m_prev_step;
            m_prev_step = step_i;
            m_done      = 0;
            if (!m_running) begin
                m_sc = 0;
                if (start_i) begin
                    m_running = 1;
                    m_single  = step_mode_i;
                    m_wrap    = 0;
                end
            end else if (hlt_i) begin
                m_running = 0;
                m_sc      = 0;
            end else if (sc_clr_i) begin
                m_sc   = 0;
                m_done = 1;
            end else if (stall_i) begin
                m_sc = m_sc;
            end else if (!m_single || m_rise) begin
                if (m_sc == LAST) begin
                    m_sc   = 0;
                    m_wrap = 1;
                end else begin
                    m_sc = m_sc + 1;
                end
            end
        end
    end

    // Compare process: DUT versus model on every falling edge.
    always @(negedge clk) begin
        check("model_sc",   int'(sc_code_o),    m_sc);
        check("model_run",  int'(run_o),        int'(m_running));
        check("model_done", int'(instr_done_o), int'(m_done));
        check("model_wrap", int'(wrap_err_o),   int'(m_wrap));
    end

    // Advance one clock; returns just after the following falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_compared = 0; n_mismatched = 0;
        rst_n = 1'b0; start_i = 1'b0; hlt_i = 1'b0; sc_clr_i = 1'b0;
        stall_i = 1'b0; step_mode_i = 1'b0; step_i = 1'b0;
        ticks(2);
        check("reset_sc", int'(sc_code_o), 0);
        check("reset_run", int'(run_o), 0);
        check("reset_done", int'(instr_done_o), 0);
        check("reset_wrap", int'(wrap_err_o), 0);
        rst_n = 1'b1;
        tick();

        // Free run: start then T0, T1, T2, T3.
        start_i = 1'b1; tick(); start_i = 1'b0;
        check("start_run", int'(run_o), 1);
        check("start_sc0", int'(sc_code_o), 0);
        tick(); check("run_sc1", int'(sc_code_o), 1);
        tick(); check("run_sc2", int'(sc_code_o), 2);
        tick(); check("run_sc3", int'(sc_code_o), 3);

        // End of instruction at SC=3.
        sc_clr_i = 1'b1; tick(); sc_clr_i = 1'b0;
        check("clr_sc", int'(sc_code_o), 0);
        check("clr_done", int'(instr_done_o), 1);
        tick();
        check("done_one_cycle", int'(instr_done_o), 0);
        check("after_clr_sc", int'(sc_code_o), 1);

        // Stall at SC=2 for three cycles.
        tick(); check("pre_stall_sc", int'(sc_code_o), 2);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall_hold", int'(sc_code_o), 2);
        end
        stall_i = 1'b0; tick();
        check("stall_resume", int'(sc_code_o), 3);
        sc_clr_i = 1'b1; stall_i = 1'b1; tick();
        sc_clr_i = 1'b0; stall_i = 1'b0;
        check("clr_beats_stall", int'(sc_code_o), 0);
        check("clr_stall_done", int'(instr_done_o), 1);

        // Run past the last step.
        ticks(7); check("at_last", int'(sc_code_o), 7);
        check("no_wrap_yet", int'(wrap_err_o), 0);
        tick();
        check("wrap_sc", int'(sc_code_o), 0);
        check("wrap_flag", int'(wrap_err_o), 1);
        ticks(5); check("pre_hlt_sc", int'(sc_code_o), 5);
        check("wrap_sticky", int'(wrap_err_o), 1);

        // Halt at SC=5.
        hlt_i = 1'b1; tick(); hlt_i = 1'b0;
        check("hlt_run", int'(run_o), 0);
        check("hlt_sc", int'(sc_code_o), 0);
        check("hlt_no_done", int'(instr_done_o), 0);
        check("hlt_wrap_kept", int'(wrap_err_o), 1);

        // Single-step mode.
        step_mode_i = 1'b1; start_i = 1'b1; tick();
        start_i = 1'b0; step_mode_i = 1'b0;
        check("step_start_run", int'(run_o), 1);
        check("step_start_wrap_clr", int'(wrap_err_o), 0);
        check("step_start_sc", int'(sc_code_o), 0);
        step_i = 1'b1; tick();
        check("step_first", int'(sc_code_o), 1);
        ticks(4); check("step_held_once", int'(sc_code_o), 1);
        step_i = 1'b0; tick(); step_i = 1'b1; tick();
        check("step_second", int'(sc_code_o), 2);
        step_i = 1'b0; tick(); step_i = 1'b1; tick();
        check("step_third", int'(sc_code_o), 3);

        // start_i mid-run is ignored; mode stays single-step.
        start_i = 1'b1; tick(); start_i = 1'b0;
        ticks(2); check("start_ignored", int'(sc_code_o), 3);

        // hlt and start together while running: hlt wins.
        hlt_i = 1'b1; start_i = 1'b1; tick();
        check("hlt_wins_run", int'(run_o), 0);
        // Together while halted: start wins (free-run mode now).
        tick(); hlt_i = 1'b0; start_i = 1'b0; step_i = 1'b0;
        check("start_wins_halted", int'(run_o), 1);
        ticks(4); check("mid_run_sc4", int'(sc_code_o), 4);

        // Asynchronous reset mid-instruction.
        #2 rst_n = 1'b0;
        #1;
        check("areset_sc", int'(sc_code_o), 0);
        check("areset_run", int'(run_o), 0);
        check("areset_done", int'(instr_done_o), 0);
        check("areset_wrap", int'(wrap_err_o), 0);
        tick(); rst_n = 1'b1;
        tick(); check("post_reset_run", int'(run_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_sequence_counter_ctrl
